cmd_dispatch: RTL and testbench

- Command sequencer between the host SPI command decoder and the command slaves (AD9866 control, radio, control block); runs in the clk_internal domain.
- Buffers host command words in a small FIFO and issues them one at a time as cmd_addr/cmd_data plus a one-cycle cmd_rqst pulse.
- Waits for an ack from every enabled slave before issuing the next command; a timeout guards against a hung slave.
- Replaces free-running cmd_cnt toggling, so no command is lost when the host writes faster than the slower slaves finish.

---
 rtl/cmd_dispatch.sv | 147 ++++++++++++++
 tb/tb_cmd_dispatch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch.sv
// Command sequencer: queues host command words and issues them one at a time,
// waiting for every enabled slave to ack (or a timeout) before the next issue.
module cmd_dispatch #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NS      = 3,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned GAP     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [5:0]             in_addr,
   input  logic [31:0]            in_data,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic [NS-1:0]          ack_en,
   input  logic [NS-1:0]          slv_ack,
   input  logic                   clr_status,
   output logic [5:0]             cmd_addr,
   output logic [31:0]            cmd_data,
   output logic                   cmd_rqst,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   timeout_err,
   output logic [NS-1:0]          to_slaves
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   // wait counter only needs to hold 0..TIMEOUT-1
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_GAP
   } state_t;

   state_t        state;
   logic [5:0]    mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [NS-1:0] pending;
   logic [NS-1:0] pend_left;
   logic [WW-1:0] wait_cnt;
   logic [GW-1:0] gap_cnt;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          to_hit;

   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == PW'(DEPTH));
   assign empty     = (level == '0);
   assign in_ready  = !full && !flush;
   assign push      = in_valid && in_ready;
   // a flush discards the head too, so nothing is issued on that edge
   assign pop       = (state == S_IDLE) && !empty && !flush;
   assign pend_left = pending & ~slv_ack;
   // final ack beats the timeout because pend_left is tested first
   assign to_hit    = (state == S_WAIT) && (pend_left != '0) && (wait_cnt == WW'(TIMEOUT - 1));
   assign busy      = (state != S_IDLE) || !empty;

   // FIFO storage; contents need no reset, the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr[AW-1:0]] <= in_addr;
         mem_data[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   // FIFO pointers, one bit wider than the index to tell full from empty
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // sticky status bits; a set event wins over clr_status
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         to_slaves   <= '0;
      end else begin
         if (in_valid && !in_ready) overflow <= 1'b1;
         else if (clr_status)       overflow <= 1'b0;
         if (to_hit) begin
            timeout_err <= 1'b1;
            to_slaves   <= pend_left;
         end else if (clr_status) begin
            timeout_err <= 1'b0;
            to_slaves   <= '0;
         end
      end
   end

   // issue / wait-for-acks / inter-command gap sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cmd_addr <= '0;
         cmd_data <= '0;
         cmd_rqst <= 1'b0;
         pending  <= '0;
         wait_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         cmd_rqst <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  cmd_addr <= mem_addr[rd_ptr[AW-1:0]];
                  cmd_data <= mem_data[rd_ptr[AW-1:0]];
                  cmd_rqst <= 1'b1;
                  pending  <= ack_en;
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               pending <= pend_left;
               if ((pend_left == '0) || to_hit) begin
                  gap_cnt <= '0;
                  state   <= (GAP == 0) ? S_IDLE : S_GAP;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == GW'(GAP - 1)) state <= S_IDLE;
               else                         gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: vector table, directed corner sequences and a
// randomized run, all checked against a transaction-timing reference model.
module tb_cmd_dispatch;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned NS      = 3;
   localparam int unsigned TIMEOUT = 255;
   localparam int unsigned GAP     = 2;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        in_valid   = 1'b0;
   logic [5:0]  in_addr    = '0;
   logic [31:0] in_data    = '0;
   logic        flush      = 1'b0;
   logic [2:0]  ack_en     = '0;
   logic [2:0]  slv_ack    = '0;
   logic        clr_status = 1'b0;
   logic        in_ready;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_rqst;
   logic        busy;
   logic [2:0]  level;
   logic        overflow;
   logic        timeout_err;
   logic [2:0]  to_slaves;

   cmd_dispatch #(.DEPTH(DEPTH), .NS(NS), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
      .in_ready(in_ready), .flush(flush), .ack_en(ack_en), .slv_ack(slv_ack),
      .clr_status(clr_status), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_rqst(cmd_rqst), .busy(busy), .level(level), .overflow(overflow),
      .timeout_err(timeout_err), .to_slaves(to_slaves)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } cmd_t;

   // reference model: a command queue plus edge-time bookkeeping
   cmd_t        mq[$];
   logic [5:0]  seen[$];
   logic        m_rqst = 1'b0;
   logic [5:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   logic        m_ovf = 1'b0;
   logic        m_terr = 1'b0;
   logic [2:0]  m_tos = '0;
   logic [2:0]  m_pend = '0;
   logic        m_in_txn = 1'b0;
   int          m_issue_e = 0;
   int          m_tfree = 0;
   int          m_e = 0;

   typedef struct packed {
      logic        v;
      logic [5:0]  a;
      logic [31:0] d;
      logic [2:0]  ack;
      logic        e_rqst;
      logic [5:0]  e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_lvl;
      logic        e_busy;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // advance the model across one clock edge using the inputs now applied
   task automatic model_edge();
      logic rdy;
      logic issue;
      logic to_ev;
      cmd_t c;
      rdy = (mq.size() < DEPTH) && !flush;
      if (rst) begin
         mq.delete();
         m_rqst = 1'b0; m_addr = '0; m_data = '0;
         m_ovf = 1'b0; m_terr = 1'b0; m_tos = '0; m_pend = '0;
         m_in_txn = 1'b0;
         m_tfree = m_e + 1;
      end else begin
         to_ev = 1'b0;
         issue = !m_in_txn && (m_e >= m_tfree) && (mq.size() != 0) && !flush;
         m_rqst = 1'b0;
         if (m_in_txn) begin
            m_pend = m_pend & ~slv_ack;
            if (m_pend == 3'b000) begin
               m_in_txn = 1'b0;
               m_tfree = m_e + int'(GAP) + 1;
            end else if (m_e - m_issue_e == int'(TIMEOUT)) begin
               to_ev = 1'b1;
               m_in_txn = 1'b0;
               m_tfree = m_e + int'(GAP) + 1;
            end
         end
         if (flush) mq.delete();
         else if (issue) begin
            c = mq.pop_front();
            m_addr = c.a; m_data = c.d; m_rqst = 1'b1;
            m_in_txn = 1'b1; m_pend = ack_en; m_issue_e = m_e;
         end
         if (in_valid && rdy) mq.push_back({in_addr, in_data});
         if (in_valid && !rdy) m_ovf = 1'b1;
         else if (clr_status)  m_ovf = 1'b0;
         if (to_ev) begin
            m_terr = 1'b1; m_tos = m_pend;
         end else if (clr_status) begin
            m_terr = 1'b0; m_tos = '0;
         end
      end
      m_e++;
   endtask

   // one clock cycle: inputs already driven, compare after the edge, clear pulses
   task automatic step();
      logic exp_rdy;
      logic exp_busy;
      #1;
      exp_rdy = (mq.size() < DEPTH) && !flush;
      if (!rst) chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
      model_edge();
      @(posedge clk);
      @(negedge clk);
      exp_busy = m_in_txn || (m_e < m_tfree) || (mq.size() != 0);
      chk("m_cmd_rqst", 64'(cmd_rqst), 64'(m_rqst));
      chk("m_cmd_addr", 64'(cmd_addr), 64'(m_addr));
      chk("m_cmd_data", 64'(cmd_data), 64'(m_data));
      chk("m_level", 64'(level), 64'(mq.size()));
      chk("m_busy", 64'(busy), 64'(exp_busy));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_timeout_err", 64'(timeout_err), 64'(m_terr));
      chk("m_to_slaves", 64'(to_slaves), 64'(m_tos));
      if (cmd_rqst) seen.push_back(cmd_addr);
      in_valid = 1'b0; flush = 1'b0; slv_ack = '0; clr_status = 1'b0; rst = 1'b0;
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      in_valid = 1'b1; in_addr = a; in_data = d;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      seen.delete();
   endtask

   task automatic check_reset(input string tg);
      chk({tg, "_rqst"}, 64'(cmd_rqst), 64'(0));
      chk({tg, "_addr"}, 64'(cmd_addr), 64'(0));
      chk({tg, "_data"}, 64'(cmd_data), 64'(0));
      chk({tg, "_busy"}, 64'(busy), 64'(0));
      chk({tg, "_level"}, 64'(level), 64'(0));
      chk({tg, "_ovf"}, 64'(overflow), 64'(0));
      chk({tg, "_terr"}, 64'(timeout_err), 64'(0));
      chk({tg, "_tos"}, 64'(to_slaves), 64'(0));
      chk({tg, "_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      // first command with staggered acks, second issues GAP cycles after the last ack
      tbl[0]  = '{1'b1, 6'h12, 32'hDEADBEEF, 3'b000, 1'b0, 6'h00, 32'h00000000, 3'd1, 1'b1};
      tbl[1]  = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b1, 6'h12, 32'hDEADBEEF, 3'd0, 1'b1};
      tbl[2]  = '{1'b1, 6'h21, 32'h0BADF00D, 3'b000, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[3]  = '{1'b0, 6'h00, 32'h00000000, 3'b001, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[4]  = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[5]  = '{1'b0, 6'h00, 32'h00000000, 3'b010, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[6]  = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[7]  = '{1'b0, 6'h00, 32'h00000000, 3'b100, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[8]  = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[9]  = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h12, 32'hDEADBEEF, 3'd1, 1'b1};
      tbl[10] = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b1, 6'h21, 32'h0BADF00D, 3'd0, 1'b1};
      tbl[11] = '{1'b0, 6'h00, 32'h00000000, 3'b111, 1'b0, 6'h21, 32'h0BADF00D, 3'd0, 1'b1};
      tbl[12] = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h21, 32'h0BADF00D, 3'd0, 1'b1};
      tbl[13] = '{1'b0, 6'h00, 32'h00000000, 3'b000, 1'b0, 6'h21, 32'h0BADF00D, 3'd0, 1'b0};

      do_reset();
      check_reset("rst0");

      ack_en = 3'b111;
      for (int i = 0; i < 14; i++) begin
         in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d;
         slv_ack = tbl[i].ack;
         step();
         chk("tbl_rqst", 64'(cmd_rqst), 64'(tbl[i].e_rqst));
         chk("tbl_addr", 64'(cmd_addr), 64'(tbl[i].e_addr));
         chk("tbl_data", 64'(cmd_data), 64'(tbl[i].e_data));
         chk("tbl_level", 64'(level), 64'(tbl[i].e_lvl));
         chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
      end

      // back-to-back burst into a slow slave: fill, overflow, then drain in order
      do_reset();
      ack_en = 3'b001;
      for (int k = 0; k < 5; k++) push(6'(k + 1), 32'h10000000 + 32'(k));
      chk("ovf_level_full", 64'(level), 64'(4));
      chk("ovf_ready_low", 64'(in_ready), 64'(0));
      chk("ovf_not_yet", 64'(overflow), 64'(0));
      push(6'h3F, 32'hFFFFFFFF);
      chk("ovf_set", 64'(overflow), 64'(1));
      chk("ovf_level_hold", 64'(level), 64'(4));
      for (int c = 0; c < 40; c++) begin
         slv_ack = 3'b001;
         step();
      end
      chk("ovf_issue_count", 64'(seen.size()), 64'(5));
      for (int k = 0; k < 5; k++)
         chk("ovf_issue_order", (k < seen.size()) ? 64'(seen[k]) : 64'hFF, 64'(k + 1));

      // timeout on slave 1, clear, next issue, then final ack on the timeout cycle
      do_reset();
      ack_en = 3'b010;
      push(6'h2A, 32'hA5A50001);
      push(6'h2B, 32'hA5A50002);
      chk("to_issue_a", 64'(cmd_rqst), 64'(1));
      chk("to_issue_a_addr", 64'(cmd_addr), 64'(6'h2A));
      for (int n = 1; n <= 258; n++) begin
         if (n == 256) clr_status = 1'b1;
         step();
         if (n == 254) chk("to_not_early", 64'(timeout_err), 64'(0));
         if (n == 255) begin
            chk("to_err_set", 64'(timeout_err), 64'(1));
            chk("to_mask", 64'(to_slaves), 64'(3'b010));
         end
         if (n == 256) begin
            chk("clr_err", 64'(timeout_err), 64'(0));
            chk("clr_mask", 64'(to_slaves), 64'(0));
         end
         if (n == 257) chk("to_gap_quiet", 64'(cmd_rqst), 64'(0));
         if (n == 258) begin
            chk("to_next_rqst", 64'(cmd_rqst), 64'(1));
            chk("to_next_addr", 64'(cmd_addr), 64'(6'h2B));
         end
      end
      for (int n = 1; n <= 255; n++) begin
         if (n == 255) slv_ack = 3'b010;
         step();
      end
      chk("ack_wins_err", 64'(timeout_err), 64'(0));
      chk("ack_wins_mask", 64'(to_slaves), 64'(0));
      chk("ack_wins_gap", 64'(busy), 64'(1));
      for (int c = 0; c < 4; c++) step();

      // flush with a concurrent write while one command is in flight
      do_reset();
      ack_en = 3'b001;
      for (int k = 0; k < 4; k++) push(6'(32 + k), 32'(k));
      chk("fl_level_pre", 64'(level), 64'(3));
      in_valid = 1'b1; in_addr = 6'h3E; in_data = 32'h3E3E3E3E; flush = 1'b1;
      #1;
      chk("fl_ready_low", 64'(in_ready), 64'(0));
      step();
      chk("fl_level_clr", 64'(level), 64'(0));
      chk("fl_ovf", 64'(overflow), 64'(1));
      chk("fl_inflight_busy", 64'(busy), 64'(1));
      slv_ack = 3'b001;
      step();
      for (int c = 0; c < 10; c++) step();
      chk("fl_done_idle", 64'(busy), 64'(0));
      chk("fl_issue_count", 64'(seen.size()), 64'(1));

      // reset in WAIT, then ack-less command and pointer wrap over 3*DEPTH commands
      do_reset();
      ack_en = 3'b001;
      push(6'h05, 32'h00000005);
      step();
      chk("rw_issue", 64'(cmd_rqst), 64'(1));
      step();
      chk("rw_wait_busy", 64'(busy), 64'(1));
      do_reset();
      check_reset("rw_rst");
      for (int c = 0; c < 5; c++) step();
      chk("rw_no_reissue", 64'(seen.size()), 64'(0));
      ack_en = 3'b000;
      push(6'h06, 32'h00000006);
      step();
      chk("na_issue", 64'(cmd_rqst), 64'(1));
      step();
      chk("na_busy1", 64'(busy), 64'(1));
      step();
      chk("na_busy2", 64'(busy), 64'(1));
      step();
      chk("na_idle3", 64'(busy), 64'(0));
      seen.delete();
      begin
         int k;
         k = 0;
         for (int c = 0; c < 150; c++) begin
            if (k < 3 * int'(DEPTH) && in_ready) begin
               in_valid = 1'b1; in_addr = 6'(16 + k); in_data = 32'(k) * 32'h01010101;
               k++;
            end
            step();
         end
      end
      chk("wrap_count", 64'(seen.size()), 64'(3 * DEPTH));
      for (int j = 0; j < 3 * int'(DEPTH); j++)
         chk("wrap_order", (j < seen.size()) ? 64'(seen[j]) : 64'hFF, 64'(16 + j));

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) ack_en = 3'($urandom);
         in_valid   = 1'($urandom_range(0, 1));
         in_addr    = 6'($urandom);
         in_data    = $urandom;
         slv_ack    = 3'($urandom) & 3'($urandom);
         flush      = ($urandom_range(0, 39) == 0);
         clr_status = ($urandom_range(0, 29) == 0);
         rst        = ($urandom_range(0, 599) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
